// File: rtl/bsg_wormhole_router_pkg.sv
// bsg_wormhole_router_pkg: shared header layout and arbiter FSM states
package bsg_wormhole_router_pkg;
  localparam int cord_width_lp = 4;
  localparam int len_width_lp = 2;
  typedef struct packed {
    logic [len_width_lp-1:0] len;
    logic [cord_width_lp-1:0] cord;
  } header_s;
  typedef enum logic {IDLE, LOCKED} state_e;
endpackage

// File: rtl/bsg_arb_round_robin_ptr.sv
// bsg_arb_round_robin_ptr: picks the first request after the last winner, with wrap-around
module bsg_arb_round_robin_ptr #(
  parameter int els_p = 4
) (
  input  logic [els_p-1:0]         reqs,
  input  logic [$clog2(els_p)-1:0] last,
  output logic [els_p-1:0]         grant,
  output logic [$clog2(els_p)-1:0] idx,
  output logic                     v
);
  localparam int lg_els_lp = $clog2(els_p);
  always_comb begin
    grant = '0;
    idx = '0;
    v = 1'b0;
    for (int i = els_p; i >= 1; i--)
      if (reqs[(int'(last) + i) % els_p]) begin
        idx = lg_els_lp'((int'(last) + i) % els_p);
        v = 1'b1;
      end
    grant = v ? els_p'(1) << idx : '0;
  end
endmodule

// File: rtl/bsg_wormhole_router_input_arbiter.sv
// bsg_wormhole_router_input_arbiter: packet-granular round-robin arbiter onto one wormhole link
module bsg_wormhole_router_input_arbiter
  import bsg_wormhole_router_pkg::*;
#(
  parameter int els_p = 4,
  parameter int flit_width_p = 8,
  parameter int cord_width_p = 4,
  parameter int len_width_p = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [els_p-1:0]                v_i,
  input  logic [els_p*flit_width_p-1:0]   data_i,
  output logic [els_p-1:0]                ready_and_o,
  output logic                            v_o,
  output logic [flit_width_p-1:0]         data_o,
  input  logic                            ready_and_i,
  output logic [els_p-1:0]                grant_o,
  output logic                            locked_o
);
  localparam int lg_els_lp = $clog2(els_p);
  state_e state_r;
  logic [lg_els_lp-1:0] lock_r, ptr_r, rr_idx, sel;
  logic [len_width_p-1:0] cnt_r, len;
  logic [els_p-1:0] rr_grant;
  logic rr_v, locked, act, xfer;
  bsg_arb_round_robin_ptr #(.els_p(els_p)) rr (
    .reqs(v_i),
    .last(ptr_r),
    .grant(rr_grant),
    .idx(rr_idx),
    .v(rr_v)
  );
  assign locked = state_r == LOCKED;
  assign act = reset_n_i & (locked | rr_v);
  assign sel = locked ? lock_r : rr_idx;
  assign grant_o = !act ? '0 : locked ? els_p'(1) << lock_r : rr_grant;
  assign v_o = act & v_i[sel];
  assign data_o = act ? data_i[sel*flit_width_p +: flit_width_p] : '0;
  assign ready_and_o = grant_o & {els_p{ready_and_i}};
  assign locked_o = reset_n_i & locked;
  assign xfer = v_o & ready_and_i;
  assign len = data_o[cord_width_p +: len_width_p];
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= IDLE;
      lock_r <= '0;
      cnt_r <= '0;
      ptr_r <= lg_els_lp'(els_p - 1);
    end else if (xfer) begin
      if (locked) begin
        cnt_r <= cnt_r - len_width_p'(1);
        if (cnt_r == len_width_p'(1)) begin
          state_r <= IDLE;
          ptr_r <= lock_r;
        end
      end else if (len == '0)
        ptr_r <= rr_idx;
      else begin
        state_r <= LOCKED;
        lock_r <= rr_idx;
        cnt_r <= len;
      end
    end
endmodule

// File: tb/tb_bsg_wormhole_router_input_arbiter.sv
// tb_bsg_wormhole_router_input_arbiter: directed and random checks against a packet-level model
module tb_bsg_wormhole_router_input_arbiter;
  import bsg_wormhole_router_pkg::*;
  logic clk = 1'b0;
  logic reset_n_i;
  logic [3:0] v_i, ready_and_o, grant_o;
  logic [31:0] data_i;
  logic v_o, ready_and_i, locked_o;
  logic [7:0] data_o;
  always #5 clk = ~clk;
  bsg_wormhole_router_input_arbiter dut (
    .clk_i(clk),
    .reset_n_i(reset_n_i),
    .v_i(v_i),
    .data_i(data_i),
    .ready_and_o(ready_and_o),
    .v_o(v_o),
    .data_o(data_o),
    .ready_and_i(ready_and_i),
    .grant_o(grant_o),
    .locked_o(locked_o)
  );
  logic [7:0] q[4][$];
  int log_src[$];
  logic [7:0] log_flit[$];
  logic [3:0] obs_grant[$];
  logic obs_lock[$];
  logic [7:0] exp_flits[$];
  logic [3:0] stall;
  logic rdy;
  bit m_locked;
  int m_owner, m_rem, m_last;
  int n_cmp = 0, n_err = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_pkt(int k, int len);
    header_s h;
    h.len = 2'(len);
    h.cord = 4'($urandom);
    q[k].push_back({2'($urandom), h});
    for (int i = 0; i < len; i++) q[k].push_back(8'($urandom));
  endtask
  task automatic clear_obs();
    log_src.delete();
    log_flit.delete();
    obs_grant.delete();
    obs_lock.delete();
  endtask
  task automatic clear_queues();
    for (int k = 0; k < 4; k++) q[k].delete();
  endtask
  task automatic tick();
    int s;
    bit have;
    logic [3:0] e_grant;
    logic [7:0] e_data;
    logic e_v;
    for (int k = 0; k < 4; k++) begin
      v_i[k] = q[k].size() > 0 && !stall[k];
      data_i[k*8 +: 8] = q[k].size() > 0 ? q[k][0] : 8'h00;
    end
    ready_and_i = rdy;
    if (!reset_n_i) begin
      m_locked = 0;
      m_rem = 0;
      m_last = 3;
    end
    #1;
    s = 0;
    have = 0;
    if (m_locked) begin
      s = m_owner;
      have = 1;
    end else
      for (int i = 1; i <= 4 && !have; i++)
        if (v_i[(m_last + i) % 4]) begin
          s = (m_last + i) % 4;
          have = 1;
        end
    if (!reset_n_i) have = 0;
    e_grant = have ? 4'(1 << s) : 4'h0;
    e_v = have && v_i[s];
    e_data = have ? data_i[s*8 +: 8] : 8'h00;
    chk("grant", grant_o, e_grant);
    chk("v_o", v_o, e_v);
    chk("data_o", data_o, e_data);
    chk("ready_and_o", ready_and_o, rdy ? e_grant : 4'h0);
    chk("locked_o", locked_o, reset_n_i && m_locked);
    obs_grant.push_back(grant_o);
    obs_lock.push_back(locked_o);
    @(posedge clk);
    if (reset_n_i && e_v && rdy) begin
      log_src.push_back(s);
      log_flit.push_back(e_data);
      void'(q[s].pop_front());
      if (!m_locked) begin
        if (e_data[5:4] == 0) m_last = s;
        else begin
          m_locked = 1;
          m_owner = s;
          m_rem = int'(e_data[5:4]);
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_locked = 0;
          m_last = m_owner;
        end
      end
    end
    #1;
  endtask
  initial begin
    int nl;
    reset_n_i = 1'b0;
    v_i = '0;
    data_i = '0;
    ready_and_i = 1'b0;
    stall = '0;
    rdy = 1'b1;
    m_locked = 0;
    m_rem = 0;
    m_last = 3;
    m_owner = 0;
    for (int k = 0; k < 4; k++) push_pkt(k, 0);
    repeat (4) tick();
    reset_n_i = 1'b1;
    clear_obs();
    tick();
    chk("rel_grant", obs_grant[0], 4'b0001);
    repeat (3) tick();
    chk("rst_cnt", log_src.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_order%0d", i), log_src[i], i);
    clear_obs();
    push_pkt(2, 2);
    repeat (4) tick();
    chk("single_cnt", log_src.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("single_src%0d", i), log_src[i], 2);
      chk($sformatf("single_grant%0d", i), obs_grant[i], 4'b0100);
    end
    chk("single_lock0", obs_lock[0], 0);
    chk("single_lock1", obs_lock[1], 1);
    chk("single_lock2", obs_lock[2], 1);
    chk("single_lock3", obs_lock[3], 0);
    clear_obs();
    push_pkt(0, 3);
    push_pkt(1, 0);
    tick();
    tick();
    stall = 4'b0001;
    tick();
    tick();
    stall = '0;
    repeat (3) tick();
    chk("worm_cnt", log_src.size(), 5);
    for (int i = 0; i < 4; i++) chk($sformatf("worm_src%0d", i), log_src[i], 0);
    chk("worm_src4", log_src[4], 1);
    chk("worm_bubble_grant", obs_grant[2], 4'b0001);
    chk("worm_bubble_lock", obs_lock[3], 1);
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    tick();
    clear_obs();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) push_pkt(k, 1);
    repeat (16) tick();
    chk("rr_cnt", log_src.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("rr_src%0d", i), log_src[i], (i / 2) % 4);
    clear_obs();
    push_pkt(3, 3);
    exp_flits = q[3];
    for (int i = 0; i < 8; i++) begin
      rdy = (i % 2 == 0);
      tick();
    end
    rdy = 1'b1;
    chk("bp_cnt", log_src.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_flit%0d", i), log_flit[i], exp_flits[i]);
    chk("bp_lock6", obs_lock[6], 1);
    chk("bp_lock7", obs_lock[7], 0);
    clear_obs();
    push_pkt(1, 0);
    push_pkt(3, 0);
    push_pkt(1, 0);
    push_pkt(3, 0);
    repeat (4) tick();
    chk("zl_cnt", log_src.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("zl_src%0d", i), log_src[i], i % 2 ? 3 : 1);
    nl = 0;
    foreach (obs_lock[i]) nl += int'(obs_lock[i]);
    chk("zl_nolock", nl, 0);
    clear_obs();
    push_pkt(2, 3);
    tick();
    tick();
    chk("mid_locked", obs_lock[1], 1);
    reset_n_i = 1'b0;
    clear_queues();
    push_pkt(2, 0);
    push_pkt(0, 0);
    tick();
    chk("mid_rst_lock", obs_lock[2], 0);
    chk("mid_rst_grant", obs_grant[2], 0);
    reset_n_i = 1'b1;
    clear_obs();
    tick();
    chk("mid_next_grant", obs_grant[0], 4'b0001);
    chk("mid_next_src", log_src[0], 0);
    clear_queues();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++)
        if (q[k].size() == 0 && $urandom_range(3) == 0) push_pkt(k, int'($urandom_range(3)));
      stall = 4'($urandom) & 4'($urandom);
      rdy = $urandom_range(3) != 0;
      reset_n_i = $urandom_range(99) != 0;
      if (!reset_n_i) clear_queues();
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bsg_wormhole_router_input_arbiter.md
Name: bsg_wormhole_router_input_arbiter

Overview:
- Packet-granular arbiter that shares one wormhole flit link (e.g. the output of a bsg_wormhole_router_adapter_in) among els_p flit-stream requesters.
- Arbitration happens only at packet boundaries, using round-robin on header flits.
- Once a header is accepted, the grant stays locked to that requester until its last body flit transfers, so packets never interleave.
- Sits between several adapters/injectors and a single router input port.

Parameters:
- els_p, 4, number of requesters (>=2).
- flit_width_p, 8, flit width in bits.
- cord_width_p, 4, destination coordinate width; occupies header bits [cord_width_p-1:0].
- len_width_p, 2, length field width; occupies header bits [cord_width_p+:len_width_p]. The value is the number of body flits following the header.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  els_p  per-requester flit valid.
- data_i  in  els_p*flit_width_p  per-requester flit; requester k occupies slice [k*flit_width_p+:flit_width_p].
- ready_and_o  out  els_p  per-requester ready-and.
- v_o  out  1  link flit valid.
- data_o  out  flit_width_p  link flit.
- ready_and_i  in  1  link ready-and from downstream.
- grant_o  out  els_p  one-hot, current selected requester; all zeros if none.
- locked_o  out  1  high while mid-packet (in LOCKED state).

Behaviour:
- Interface decided: one clock, clk_i; reset_n_i is asynchronous and active-low.
- Handshake: a transfer occurs when v_o & ready_and_i. Input k transfers when v_i[k] & ready_and_o[k].
- Datapath is combinational pass-through with zero latency and no storage.
- For the selected requester s: data_o = data_i[s], v_o = v_i[s], ready_and_o[s] = ready_and_i.
- All non-selected ready_and_o bits = 0.
- State: two-state FSM {IDLE, LOCKED}, plus a lock index register, a remaining-flit counter (len_width_p bits) and an rr pointer (last winner).
- Reset: asynchronous on reset_n_i low.
  - FSM -> IDLE, counter -> 0, rr pointer -> els_p-1, so requester 0 has top priority first.
  - While reset is asserted: v_o=0, ready_and_o=0, grant_o=0, locked_o=0, data_o=0.
- IDLE:
  - s = first k with v_i[k]=1, searching from pointer+1 upward with wrap-around.
  - No v_i set -> grant_o=0, v_o=0.
  - On a header transfer with len = data_o[cord_width_p+:len_width_p]:
    - len==0 (single-flit packet): stay IDLE, pointer <= s.
    - len>0: -> LOCKED, lock index <= s, counter <= len.
  - No transfer (ready_and_i=0): no state change; the choice may change next cycle as v_i changes.
- LOCKED:
  - s = lock index, regardless of other v_i; grant_o stays one-hot on s even when v_i[s]=0.
  - Each transfer decrements the counter.
  - Transfer with counter==1 -> IDLE, pointer <= lock index.
  - Bubbles are allowed: v_i[s]=0 holds state.
  - Body-flit contents are never interpreted.
- Fairness: with all requesters continuously valid, packet grants rotate 0,1,2,3,0,...
- Reset asserted mid-packet: abort immediately to IDLE. The partial packet is not completed, and upstream/downstream are reset together.
- Counter never underflows; len is at most 2^len_width_p-1.
- No combinational path from ready_and_i to v_o; ready_and_o depends on v_i only in IDLE.

Decomposition:
- Shared package bsg_wormhole_router_pkg holds:
  - the header typedef struct {len, cord}, with len above cord;
  - the FSM state enum.
- Natural sub-module: bsg_arb_round_robin_ptr, a pointer-based round-robin priority selector.
  - Inputs: reqs and the last pointer.
  - Outputs: one-hot grant and encoded index.
  - The pointer is updated only on the yumi/advance signal.

Test Plan:
- Reset: hold reset_n_i low 4 cycles with v_i=4'b1111 -> v_o=0, ready_and_o=0, grant_o=0, locked_o=0; release -> grant_o=4'b0001.
- Single packet: requester 2 sends header len=2 then 2 body flits, ready_and_i=1 -> 3 output flits on consecutive cycles. locked_o is high during the 2 body-flit cycles; grant_o=4'b0100 throughout; IDLE after the third flit.
- Wormhole lock: requester 0 header len=3, then requester 1 valid with a header -> no requester-1 flit appears until requester 0's 3 body flits transfer, even with v_i[0] dropped for 2 bubble cycles.
- Round-robin: all 4 requesters continuously offer len=1 packets -> header order 0,1,2,3,0,1; each header is followed by its own body flit.
- Backpressure: ready_and_i toggles 1,0,1,0 during a len=3 packet -> the counter decrements only on handshake cycles; exactly 4 flits are delivered, in order, no duplicates.
- Zero-length packets plus mid-packet reset: requesters 1 and 3 send len=0 headers back-to-back -> alternate grants with no LOCKED entry. Then assert reset during a len=3 packet after 2 flits -> immediate IDLE, and the next grant goes to requester 0.
